addsub_pipe: RTL and testbench
==============================

// Module: addsub_pipe
// PURPOSE
//  Two-stage pipelined integer add/sub/compare unit; direct upstream producer and downstream consumer of the KSA prefix adder.
//  Stage 1 registers the operands and builds the carry-in-extended adder inputs.
//  Stage 2 captures the KSA sum and derives ADD/SUB/SLT/SLTU results.
//  Sits in an integer issue port between select/regread and writeback; valid/ready on both sides; flushable.
// PARAMETERS
//  XLEN   64  operand/result width
//  TAG_W  7   width of the opaque tag (ROB/prf index) carried alongside each op
// PORTS
//  clk        in   1       clock
//  rst        in   1       reset, synchronous, active-high
//  flush      in   1       kill every in-flight op (stage 1 and stage 2)
//  in_valid   in   1       op presented
//  in_ready   out  1       unit accepts the op this cycle
//  in_op      in   2       addsub_op_t: ADD=00, SUB=01, SLT=10, SLTU=11
//  in_a       in   XLEN    operand A
//  in_b       in   XLEN    operand B
//  in_tag     in   TAG_W   tag, returned unchanged
//  out_valid  out  1       result valid
//  out_ready  in   1       consumer accepts the result
//  out_data   out  XLEN    result
//  out_tag    out  TAG_W   tag of the result
//  busy       out  1       s1_valid | s2_valid
// BEHAVIOUR
//  - Reset (rst=1 at posedge): s1_valid=0, s2_valid=0. out_valid=0, busy=0, in_ready=1.
//    out_data/out_tag reset to 0. rst overrides every other input.
//  - Transfer rules: input accepts on in_valid&in_ready; output retires on out_valid&out_ready.
//    out_valid=s2_valid. s2_adv = !s2_valid | out_ready. in_ready = !s1_valid | s2_adv (combinational, no skid).
//  - Latency 2: an op accepted at edge E appears on out_valid after edge E+1 when no stall.
//    Throughput is 1 op/cycle. Order is strictly preserved.
//  - Stall: with out_ready=0, s2 holds out_data/out_tag stable and s1 holds.
//    in_ready drops once s1 is full. No op is dropped or duplicated.
//  - Stage 1 prep (W = XLEN+2):
//    ADD: adder_a={1'b0,a,1'b0}, adder_b={1'b0,b,1'b0}.
//    SUB/SLT/SLTU: adder_a={1'b0,a,1'b1}, adder_b={1'b0,~b,1'b1}.
//    The LSB pair injects carry-in.
//  - KSA(PRECISION=W): sum[XLEN:1] is a±b. sum[XLEN+1] is carry-out (cout).
//  - Result select at s2 capture:
//    ADD/SUB: sum[XLEN:1] (wraps modulo 2^XLEN, no exception).
//    SLTU: {0...,!cout}.
//    SLT: {0...,lt}, where lt = (a[XLEN-1]^b[XLEN-1]) ? a[XLEN-1] : sum[XLEN].
//  - Flush: at the flushing edge, s1_valid and s2_valid are cleared.
//    flush beats a simultaneous accept: an in_valid&in_ready op in the flush cycle is discarded.
//    A result with out_valid&out_ready in the flush cycle still counts as delivered.
//  - Simultaneous retire+accept with both stages full: s2 takes s1 and s1 takes input in the same edge; no bubble.
//  - Registered datapath state is s1{op,a,b,tag} and s2{data,tag}. The KSA is the only combinational path between them.
// STRUCTURE
//  - alu_pkg (shared): typedef enum logic[1:0] addsub_op_t {ADD, SUB, SLT, SLTU}.
//  - One sub-module: KSA #(.PRECISION(XLEN+2)) instance u_ksa. No other children.
//  - Operand prep and result select are local always_comb blocks.
//  - The s1/s2 valid logic is a two-flop occupancy pipeline, not a separate FSM module.
// TESTING
//  1. ADD 0x7FFF_FFFF_FFFF_FFFF + 1 -> out_data=0x8000_0000_0000_0000 two edges later.
//     Then ADD 0xFFFF..F + 1 -> 0 (wrap).
//  2. SUB 5-7 -> 0xFFFF_FFFF_FFFF_FFFE. SUB 0-0 -> 0. Tags 0x11, 0x12 are returned in order.
//  3. SLT -1,1 -> 1. SLTU -1,1 -> 0. SLT 3,3 -> 0. SLTU 0,0xFFFF..F -> 1.
//     Also SLT 0x8000..0,0x7FFF..F -> 1 (signed overflow case).
//  4. Back-to-back 16 random ops with out_ready=1 -> 16 results in order, 1/cycle.
//     All results match a golden a±b model.
//  5. Hold out_ready=0 for 4 cycles with 3 ops offered -> 2 accepted, in_ready=0, out_data stable.
//     Release -> all 3 delivered in order.
//  6. Assert flush while both stages full and in_valid=1 -> next cycle busy=0, out_valid=0, no stale result.
//     Assert rst mid-stall -> same.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared operation encoding for the integer add/sub/compare unit
package alu_pkg;
  typedef enum logic [1:0] {ADD = 2'b00, SUB = 2'b01, SLT = 2'b10, SLTU = 2'b11} addsub_op_t;
endpackage

// File: rtl/addsub_pipe_ksa.sv
// KSA: Kogge-Stone parallel-prefix adder, carry-in supplied through the operand LSBs
module KSA #(
  parameter int PRECISION = 66
) (
  input  logic [PRECISION-1:0] i_a,
  input  logic [PRECISION-1:0] i_b,
  output logic [PRECISION-1:0] o_sum
);
  localparam int L = $clog2(PRECISION);
  logic [PRECISION-1:0] w_p0, w_g, w_p;
  assign w_p0 = i_a ^ i_b;
  // each pass doubles the prefix span; low bits keep their group propagate via the inverted shift
  always_comb begin
    w_g = i_a & i_b;
    w_p = w_p0;
    for (int k = 0; k < L; k++) begin
      w_g = w_g | (w_p & (w_g << (1 << k)));
      w_p = w_p & ~(~w_p << (1 << k));
    end
  end
  assign o_sum = w_p0 ^ {w_g[PRECISION-2:0], 1'b0};
endmodule

// File: rtl/addsub_pipe.sv
// addsub_pipe: two-stage pipelined ADD/SUB/SLT/SLTU unit with valid/ready handshakes and flush
module addsub_pipe
  import alu_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int TAG_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  addsub_op_t       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);
  localparam int W = XLEN + 2;
  logic             r_s1_valid, r_s2_valid;
  addsub_op_t       r_s1_op;
  logic [XLEN-1:0]  r_s1_a, r_s1_b, r_s2_data;
  logic [TAG_W-1:0] r_s1_tag, r_s2_tag;
  logic [W-1:0]     w_adder_a, w_adder_b, w_sum;
  logic [XLEN-1:0]  w_res;
  logic             w_s2_adv, w_lt, w_unused;
  assign w_s2_adv  = !r_s2_valid | out_ready;
  assign in_ready  = !r_s1_valid | w_s2_adv;
  assign out_valid = r_s2_valid;
  assign out_data  = r_s2_data;
  assign out_tag   = r_s2_tag;
  assign busy      = r_s1_valid | r_s2_valid;
  // the LSB pair is the carry-in: 0+0 for ADD, 1+1 for a + ~b + 1
  always_comb begin
    w_adder_a = {1'b0, r_s1_a, r_s1_op != ADD};
    w_adder_b = (r_s1_op == ADD) ? {1'b0, r_s1_b, 1'b0} : {1'b0, ~r_s1_b, 1'b1};
  end
  KSA #(.PRECISION(W)) u_ksa (.i_a(w_adder_a), .i_b(w_adder_b), .o_sum(w_sum));
  assign w_unused = w_sum[0];
  always_comb begin
    w_lt  = (r_s1_a[XLEN-1] ^ r_s1_b[XLEN-1]) ? r_s1_a[XLEN-1] : w_sum[XLEN];
    w_res = (r_s1_op == SLT)  ? {{(XLEN-1){1'b0}}, w_lt} :
            (r_s1_op == SLTU) ? {{(XLEN-1){1'b0}}, !w_sum[XLEN+1]} : w_sum[XLEN:1];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
      r_s2_tag   <= '0;
    end else if (flush) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      if (w_s2_adv) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_data <= w_res;
          r_s2_tag  <= r_s1_tag;
        end
      end
      if (in_ready) r_s1_valid <= in_valid;
    end
  end
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      r_s1_op  <= in_op;
      r_s1_a   <= in_a;
      r_s1_b   <= in_b;
      r_s1_tag <= in_tag;
    end
  end
endmodule

// File: tb/tb_addsub_pipe.sv
// tb_addsub_pipe: directed checks of arithmetic, ordering, stall, flush and reset behaviour
module tb_addsub_pipe;
  import alu_pkg::*;
  logic        clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 1;
  logic        in_ready, out_valid, busy;
  addsub_op_t  in_op = ADD;
  logic [63:0] in_a = 0, in_b = 0, out_data;
  logic [6:0]  in_tag = 0, out_tag;
  int          n_tests = 0, n_fail = 0;
  addsub_op_t  r_ops [16];
  logic [63:0] r_as [16], r_bs [16];

  addsub_pipe dut (.clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag), .busy(busy));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input addsub_op_t op, input logic [63:0] a, input logic [63:0] b, input logic [6:0] t);
    in_valid = 1; in_op = op; in_a = a; in_b = b; in_tag = t;
  endtask

  task automatic single(input string name, input addsub_op_t op, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp);
    drive(op, a, b, 7'h05);
    chk({name, "_in_ready"}, in_ready, 1);
    step();
    in_valid = 0;
    step();
    chk({name, "_valid"}, out_valid, 1);
    chk(name, out_data, exp);
    step();
  endtask

  function automatic logic [63:0] golden(input addsub_op_t op, input logic [63:0] a, input logic [63:0] b);
    case (op)
      ADD:     return a + b;
      SUB:     return a - b;
      SLT:     return {63'b0, $signed(a) < $signed(b)};
      default: return {63'b0, a < b};
    endcase
  endfunction

  initial begin
    step(); step();
    rst = 0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_tag", out_tag, 0);

    single("add_ovf", ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000);
    single("add_wrap", ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0);

    drive(SUB, 64'd5, 64'd7, 7'h11);
    step();
    drive(SUB, 64'd0, 64'd0, 7'h12);
    step();
    in_valid = 0;
    chk("sub_5_7", out_data, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("sub_tag1", out_tag, 7'h11);
    step();
    chk("sub_0_0", out_data, 64'd0);
    chk("sub_tag2", out_tag, 7'h12);
    chk("sub_valid2", out_valid, 1);
    step();
    chk("sub_drained", out_valid, 0);

    single("slt_m1_1", SLT, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1);
    single("sltu_m1_1", SLTU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0);
    single("slt_3_3", SLT, 64'd3, 64'd3, 64'd0);
    single("sltu_0_max", SLTU, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    single("slt_ovf", SLT, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    single("sub_bigneg", SUB, 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF);

    for (int i = 0; i < 16; i++) begin
      r_ops[i] = addsub_op_t'($urandom_range(0, 3));
      r_as[i]  = {$urandom, $urandom};
      r_bs[i]  = (i % 4 == 0) ? r_as[i] : {$urandom, $urandom};
    end
    for (int s = 0; s < 18; s++) begin
      if (s >= 2) begin
        chk($sformatf("rnd_valid%0d", s - 2), out_valid, 1);
        chk($sformatf("rnd_data%0d", s - 2), out_data, golden(r_ops[s-2], r_as[s-2], r_bs[s-2]));
        chk($sformatf("rnd_tag%0d", s - 2), out_tag, 7'(s - 2 + 7'h40));
      end
      if (s < 16) begin
        chk($sformatf("rnd_in_ready%0d", s), in_ready, 1);
        drive(r_ops[s], r_as[s], r_bs[s], 7'(s + 7'h40));
      end else in_valid = 0;
      step();
    end
    chk("rnd_drained", out_valid, 0);

    out_ready = 0;
    drive(ADD, 64'd1, 64'd2, 7'h21);
    step();
    chk("stall_in_ready_s1", in_ready, 1);
    drive(SUB, 64'd10, 64'd4, 7'h22);
    step();
    drive(SLTU, 64'd1, 64'd2, 7'h23);
    for (int c = 0; c < 2; c++) begin
      chk("stall_in_ready", in_ready, 0);
      chk("stall_valid", out_valid, 1);
      chk("stall_data", out_data, 64'd3);
      chk("stall_tag", out_tag, 7'h21);
      step();
    end
    out_ready = 1;
    #1;
    chk("release_in_ready", in_ready, 1);
    step();
    in_valid = 0;
    chk("rel_data_b", out_data, 64'd6);
    chk("rel_tag_b", out_tag, 7'h22);
    step();
    chk("rel_data_c", out_data, 64'd1);
    chk("rel_tag_c", out_tag, 7'h23);
    step();
    chk("rel_drained", out_valid, 0);

    out_ready = 0;
    drive(ADD, 64'd7, 64'd8, 7'h31);
    step();
    drive(ADD, 64'd9, 64'd9, 7'h32);
    step();
    drive(ADD, 64'd1, 64'd1, 7'h33);
    flush = 1;
    chk("pre_flush_busy", busy, 1);
    step();
    flush = 0;
    in_valid = 0;
    chk("flush_busy", busy, 0);
    chk("flush_out_valid", out_valid, 0);
    out_ready = 1;
    step();
    chk("flush_no_stale", out_valid, 0);
    chk("flush_busy2", busy, 0);

    out_ready = 0;
    drive(SUB, 64'd3, 64'd1, 7'h41);
    step();
    drive(SUB, 64'd4, 64'd1, 7'h42);
    step();
    in_valid = 0;
    chk("prerst_out_valid", out_valid, 1);
    rst = 1;
    step();
    rst = 0;
    chk("midrst_busy", busy, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_out_tag", out_tag, 0);
    chk("midrst_in_ready", in_ready, 1);
    out_ready = 1;
    step();
    chk("midrst_no_stale", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
